// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared state enum, default parameters and return-stack depth (optional call/ret stack enabled by FETCH_SEQ_CALL_EN)
package fetch_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_e;
    localparam int DEF_PC_W      = 12;
    localparam int DEF_LBL_W     = 8;
    localparam int DEF_LUT_DEPTH = 16;
    localparam int DEF_DONE_ADDR = 2000;
    localparam int RS_DEPTH      = 4;
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/fetch_seq_if.sv
// fetch_seq_if: control, LUT-write and status bundle of fetch_seq; call/ret/rs_err appear only with FETCH_SEQ_CALL_EN
interface fetch_seq_if #(
    parameter int PC_W      = fetch_seq_pkg::DEF_PC_W,
    parameter int LBL_W     = fetch_seq_pkg::DEF_LBL_W,
    parameter int LUT_DEPTH = fetch_seq_pkg::DEF_LUT_DEPTH
);
    localparam int IDX_W = $clog2(LUT_DEPTH);
    logic             start;
    logic             stall;
    logic             branch;
    logic [LBL_W-1:0] label;
    logic             lut_we;
    logic [IDX_W-1:0] lut_waddr;
    logic [PC_W-1:0]  lut_wdata;
    logic [PC_W-1:0]  pc;
    logic             valid;
    logic             busy;
    logic             done;
    logic [31:0]      cycles;
`ifdef FETCH_SEQ_CALL_EN
    logic             call;
    logic             ret;
    logic             rs_err;
    modport master(output start, stall, branch, label, lut_we, lut_waddr, lut_wdata, call, ret,
                   input pc, valid, busy, done, cycles, rs_err);
    modport slave(input start, stall, branch, label, lut_we, lut_waddr, lut_wdata, call, ret,
                  output pc, valid, busy, done, cycles, rs_err);
`else
    modport master(output start, stall, branch, label, lut_we, lut_waddr, lut_wdata,
                   input pc, valid, busy, done, cycles);
    modport slave(input start, stall, branch, label, lut_we, lut_waddr, lut_wdata,
                  output pc, valid, busy, done, cycles);
`endif
endinterface

// File: rtl/branch_lut.sv
// branch_lut: register file of branch targets, one write port, one combinational read port
module branch_lut #(
    parameter int W     = 12,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    // a write lands on the next edge, so a same-cycle read still returns the old entry
    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    // storage, cleared to zero on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mem_q <= '{default: '0};
        else        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: IDLE/RUN/HALT program-counter sequencer with branch LUT; FETCH_SEQ_CALL_EN adds a 4-entry return stack
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter int PC_W      = DEF_PC_W,
    parameter int LBL_W     = DEF_LBL_W,
    parameter int LUT_DEPTH = DEF_LUT_DEPTH,
    parameter int DONE_ADDR = DEF_DONE_ADDR
) (
    input  logic       clk,
    input  logic       reset,
    fetch_seq_if.slave bus
);
    localparam int IDX_W = $clog2(LUT_DEPTH);
    localparam logic [PC_W-1:0] DONE = PC_W'(DONE_ADDR);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     cycles_q, cycles_d;
    logic            valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic [PC_W-1:0] lut_rdata;
    logic            unused_label;

    assign unused_label = ^bus.label;

    branch_lut #(.W(PC_W), .DEPTH(LUT_DEPTH)) u_lut (
        .clk   (clk),
        .reset (reset),
        .we    (bus.lut_we),
        .waddr (bus.lut_waddr),
        .wdata (bus.lut_wdata),
        .raddr (bus.label[IDX_W-1:0]),
        .rdata (lut_rdata)
    );

`ifdef FETCH_SEQ_CALL_EN
    logic [PC_W-1:0] stk_q [RS_DEPTH];
    logic [PC_W-1:0] stk_d [RS_DEPTH];
    logic [1:0]      sp_q, sp_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            rs_err_q, rs_err_d;
    logic [1:0]      sp_inc;
    assign sp_inc = sp_q + 2'd1;
    assign bus.rs_err = rs_err_q;
`endif

    // next state: halt beats stall, stall beats ret/call/branch, otherwise increment
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cycles_d = cycles_q;
`ifdef FETCH_SEQ_CALL_EN
        stk_d    = stk_q;
        sp_d     = sp_q;
        cnt_d    = cnt_q;
        rs_err_d = rs_err_q;
`endif
        if (state_q == RUN) begin
            cycles_d = sat_inc(cycles_q);
            if (pc_q == DONE) state_d = HALT;
            else if (!bus.stall) begin
`ifdef FETCH_SEQ_CALL_EN
                if (bus.ret) begin
                    if (cnt_q != 3'd0) begin
                        pc_d  = stk_q[sp_q];
                        sp_d  = sp_q - 2'd1;
                        cnt_d = cnt_q - 3'd1;
                    end else begin
                        pc_d     = pc_q + 1'b1;
                        rs_err_d = 1'b1;
                    end
                end else if (bus.call) begin
                    stk_d[sp_inc] = pc_q + 1'b1;
                    sp_d          = sp_inc;
                    cnt_d         = (cnt_q == 3'(RS_DEPTH)) ? cnt_q : cnt_q + 3'd1;
                    pc_d          = lut_rdata;
                end else
`endif
                pc_d = bus.branch ? lut_rdata : pc_q + 1'b1;
            end
        end else if (bus.start) begin
            state_d  = RUN;
            pc_d     = '0;
            cycles_d = '0;
`ifdef FETCH_SEQ_CALL_EN
            sp_d     = '0;
            cnt_d    = '0;
            rs_err_d = 1'b0;
`endif
        end
        valid_d = (state_d == RUN) && (pc_d != DONE);
        busy_d  = state_d == RUN;
        done_d  = state_d == HALT;
    end

    // state, pc, counter and registered status flags; reset aborts a run at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            cycles_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef FETCH_SEQ_CALL_EN
            stk_q    <= '{default: '0};
            sp_q     <= '0;
            cnt_q    <= '0;
            rs_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cycles_q <= cycles_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef FETCH_SEQ_CALL_EN
            stk_q    <= stk_d;
            sp_q     <= sp_d;
            cnt_q    <= cnt_d;
            rs_err_q <= rs_err_d;
`endif
        end
    end

    assign bus.pc     = pc_q;
    assign bus.valid  = valid_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.cycles = cycles_q;
endmodule
